commit_scheduler: RTL and testbench
===================================

Name: commit_scheduler

Overview:
- Controller for the out-of-order core's active list (commit list).
- Allocates in-order tags at dispatch, marks entries complete from execution writebacks, and retires completed entries strictly in program order.
- Returns freed architectural register and predicate-state (PS) addresses to the rename and free-list logic on retire.
- Rolls the tail back on a branch-mispredict flush. Sits between rename/dispatch, the execution writeback buses and the free lists.

Parameters:
- AL_SIZE, `AL_SIZE (16): number of active-list entries. Must be a power of 2.
- REG_W, $clog2(`NUM_REG): architectural register address width.
- PS_W, $clog2(`NUM_PS): PS address width.
- TAG_W, $clog2(AL_SIZE): entry tag width.

Ports:
- clk  in  1  clock; all state updates on posedge
- n_rst  in  1  synchronous, active-high reset (1 = reset)
- dispatch_valid  in  1  dispatch request
- dispatch_ready  out  1  an entry can be accepted this cycle
- dispatch_use_rw  in  1  instruction writes a register
- dispatch_rw_addr  in  REG_W  destination register
- dispatch_ps_write  in  1  instruction writes PS
- dispatch_ps_addr  in  PS_W  destination PS
- dispatch_tag  out  TAG_W  tag assigned to the accepted instruction (tail index)
- wb0_valid  in  1  completion, port 0
- wb0_tag  in  TAG_W  completing tag, port 0
- wb1_valid  in  1  completion, port 1
- wb1_tag  in  TAG_W  completing tag, port 1
- flush  in  1  squash request
- flush_tag  in  TAG_W  oldest squashed entry
- retire_valid  out  1  head entry retires this cycle
- reg_return  out  1  retire_valid & head.use_rw
- r_reg  out  REG_W  head.rw_addr
- ps_return  out  1  retire_valid & head.ps_write
- r_ps  out  PS_W  head.ps_addr
- count  out  TAG_W+1  live entries
- empty  out  1  count == 0
- full  out  1  count == AL_SIZE

Behaviour:
- State:
  - head and tail pointers, each TAG_W+1 bits (extra wrap bit).
  - Per entry: complete, use_rw, rw_addr, ps_write, ps_addr.
  - count = tail - head (modulo 2^(TAG_W+1)).
- Reset (n_rst=1 at posedge): head=tail=0, all complete bits=0. Outputs then read: count=0, empty=1, full=0, retire_valid=0, reg_return=0, ps_return=0, dispatch_ready=1, dispatch_tag=0. Reset overrides any concurrent dispatch, writeback or flush.
- Liveness: tag t is live iff ((t - head[TAG_W-1:0]) mod AL_SIZE) < count.
- Dispatch:
  - dispatch_ready = !full & !flush. It is computed from registered state only; a same-cycle retire does not free a slot early.
  - dispatch_tag = tail[TAG_W-1:0], combinational.
  - On valid & ready: write the fields, clear complete, tail++.
- Writeback:
  - A valid port with a live tag sets complete at the next edge.
  - A non-live tag is ignored.
  - Both ports naming the same tag is legal (idempotent).
  - Writebacks are ignored in a flush cycle.
- Retire:
  - retire_valid = !empty & complete[head] & !(flush & flush_tag == head index). It is combinational from registered state.
  - A completion written in cycle N can retire in cycle N+1 at the earliest.
  - On retire: head++ and the head complete bit is cleared. Maximum one retire per cycle.
  - r_reg and r_ps always show the head entry fields, including when retire_valid=0.
- Flush:
  - If flush_tag is live: tail <= head + ((flush_tag - head index) mod AL_SIZE), with the wrap bit derived accordingly; complete bits of squashed entries are cleared.
  - A non-live flush_tag is a no-op, but dispatch_ready is still held low for that cycle.
  - A legal retire of an older head in the same cycle still proceeds; count reflects both.
- Simultaneous events:
  - Dispatch and retire in the same cycle: count unchanged.
  - Full, with dispatch_valid=1 and head retiring: no dispatch this cycle.
  - Wrap-around: the tag after AL_SIZE-1 is 0.

Test Plan:
- Reset: hold n_rst=1 for 2 cycles, then release -> count=0, empty=1, dispatch_ready=1, dispatch_tag=0, retire_valid=0, reg_return=0, ps_return=0.
- Fill: 17 back-to-back dispatches with no writebacks -> tags 0..15 accepted; after the 16th, full=1, count=16, dispatch_ready=0; the 17th is not accepted and tail is unchanged.
- Out-of-order completion: dispatch 3 entries with use_rw=1, rw_addr 3/5/7, ps_write 0/1/0, ps_addr x/2/x. Write back tag 2 (cycle N), tag 1 (N+1), tag 0 (N+2) -> retires in cycles N+3, N+4, N+5 with r_reg 3, 5, 7; ps_return=1 only with r_ps=2 in N+4; empty=1 afterwards.
- Wrap: stream 20 instructions, each written back the cycle after dispatch -> tags 0..15,0..3; retire order matches dispatch order; count never exceeds 2.
- Flush: dispatch tags 0..5 with tag 0 complete, then flush=1, flush_tag=3 -> that same cycle tag 0 retires and dispatch_ready=0; next cycle count=2, dispatch_tag=3. A wb on tag 4 is then ignored. A new dispatch gets tag 3 with complete=0.
- Edge races: full list with head complete and dispatch_valid=1 -> retire, no dispatch, count=15; next cycle dispatch accepted. Separately, flush with flush_tag == head while the head is complete -> retire_valid=0 and count=0 next cycle.

Source files
------------

// File: rtl/commit_scheduler.sv
// Active-list controller: allocates in-order tags, records out-of-order completions,
// retires strictly in program order and rolls the tail back on a flush.
module commit_scheduler #(
   parameter int AL_SIZE = 16,
   parameter int REG_W   = 5,
   parameter int PS_W    = 3,
   parameter int TAG_W   = $clog2(AL_SIZE)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             dispatch_valid,
   output logic             dispatch_ready,
   input  logic             dispatch_use_rw,
   input  logic [REG_W-1:0] dispatch_rw_addr,
   input  logic             dispatch_ps_write,
   input  logic [PS_W-1:0]  dispatch_ps_addr,
   output logic [TAG_W-1:0] dispatch_tag,
   input  logic             wb0_valid,
   input  logic [TAG_W-1:0] wb0_tag,
   input  logic             wb1_valid,
   input  logic [TAG_W-1:0] wb1_tag,
   input  logic             flush,
   input  logic [TAG_W-1:0] flush_tag,
   output logic             retire_valid,
   output logic             reg_return,
   output logic [REG_W-1:0] r_reg,
   output logic             ps_return,
   output logic [PS_W-1:0]  r_ps,
   output logic [TAG_W:0]   count,
   output logic             empty,
   output logic             full
);

   typedef logic [TAG_W:0]   ptr_t;
   typedef logic [TAG_W-1:0] tag_t;

   typedef struct packed {
      logic             use_rw;
      logic [REG_W-1:0] rw_addr;
      logic             ps_write;
      logic [PS_W-1:0]  ps_addr;
   } entry_t;

   localparam ptr_t FULL_COUNT = ptr_t'(AL_SIZE);

   ptr_t               head;
   ptr_t               tail;
   ptr_t               head_nxt;
   ptr_t               tail_nxt;
   logic [AL_SIZE-1:0] complete;
   logic [AL_SIZE-1:0] complete_nxt;
   entry_t             entries [AL_SIZE];
   entry_t             head_ent;

   tag_t head_idx;
   tag_t tail_idx;
   tag_t flush_off;
   logic do_dispatch;
   logic flush_hit;
   logic wb0_hit;
   logic wb1_hit;

   // Distance of a tag from the head, in program order.
   function automatic tag_t age_of(input tag_t t, input tag_t hidx);
      return t - hidx;
   endfunction

   function automatic logic is_live(input tag_t t, input tag_t hidx, input ptr_t cnt);
      return {1'b0, age_of(t, hidx)} < cnt;
   endfunction

   assign head_idx = head[TAG_W-1:0];
   assign tail_idx = tail[TAG_W-1:0];
   assign head_ent = entries[head_idx];

   assign count = tail - head;
   assign empty = (count == '0);
   assign full  = (count == FULL_COUNT);

   // Readiness looks only at registered occupancy; a retire this cycle frees its slot next cycle.
   assign dispatch_ready = !full && !flush;
   assign dispatch_tag   = tail_idx;
   assign do_dispatch    = dispatch_valid && dispatch_ready;

   assign retire_valid = !empty && complete[head_idx] && !(flush && (flush_tag == head_idx));
   assign reg_return   = retire_valid && head_ent.use_rw;
   assign r_reg        = head_ent.rw_addr;
   assign ps_return    = retire_valid && head_ent.ps_write;
   assign r_ps         = head_ent.ps_addr;

   assign flush_off = age_of(flush_tag, head_idx);
   assign flush_hit = flush && is_live(flush_tag, head_idx, count);
   assign wb0_hit   = wb0_valid && !flush && is_live(wb0_tag, head_idx, count);
   assign wb1_hit   = wb1_valid && !flush && is_live(wb1_tag, head_idx, count);

   always_comb begin
      // NOTE: every target gets its default first, so no path through the block can infer a latch.
      head_nxt = head + ptr_t'(retire_valid);
      tail_nxt = tail;
      if (flush_hit) begin
         tail_nxt = head + {1'b0, flush_off};
      end else if (do_dispatch) begin
         tail_nxt = tail + ptr_t'(1);
      end
   end

   // Clears are ordered after sets so a retiring or squashed slot never stays complete.
   always_comb begin
      complete_nxt = complete;
      for (int i = 0; i < AL_SIZE; i++) begin
         if (wb0_hit && (wb0_tag == tag_t'(i))) begin
            complete_nxt[i] = 1'b1;
         end
         if (wb1_hit && (wb1_tag == tag_t'(i))) begin
            complete_nxt[i] = 1'b1;
         end
         if (flush_hit && (age_of(tag_t'(i), head_idx) >= flush_off)) begin
            complete_nxt[i] = 1'b0;
         end
         if (do_dispatch && (tail_idx == tag_t'(i))) begin
            complete_nxt[i] = 1'b0;
         end
         if (retire_valid && (head_idx == tag_t'(i))) begin
            complete_nxt[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
      if (n_rst) begin
         head     <= '0;
         tail     <= '0;
         complete <= '0;
      end else begin
         head     <= head_nxt;
         tail     <= tail_nxt;
         complete <= complete_nxt;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the payload array is intentionally not reset; a slot is only read once dispatch has written it.
      if (!n_rst && do_dispatch) begin
         entries[tail_idx] <= '{use_rw:   dispatch_use_rw,
                                rw_addr:  dispatch_rw_addr,
                                ps_write: dispatch_ps_write,
                                ps_addr:  dispatch_ps_addr};
      end
   end

endmodule

// File: tb/tb_commit_scheduler.sv
// Self-checking bench for commit_scheduler: a queue-based program-order model checked every
// cycle, directed scenarios with literal expectations, then a randomized phase.
module tb_commit_scheduler;

   localparam int AL    = 16;
   localparam int REG_W = 5;
   localparam int PS_W  = 3;
   localparam int TAG_W = 4;

   logic             clk;
   logic             n_rst;
   logic             dispatch_valid;
   logic             dispatch_ready;
   logic             dispatch_use_rw;
   logic [REG_W-1:0] dispatch_rw_addr;
   logic             dispatch_ps_write;
   logic [PS_W-1:0]  dispatch_ps_addr;
   logic [TAG_W-1:0] dispatch_tag;
   logic             wb0_valid;
   logic [TAG_W-1:0] wb0_tag;
   logic             wb1_valid;
   logic [TAG_W-1:0] wb1_tag;
   logic             flush;
   logic [TAG_W-1:0] flush_tag;
   logic             retire_valid;
   logic             reg_return;
   logic [REG_W-1:0] r_reg;
   logic             ps_return;
   logic [PS_W-1:0]  r_ps;
   logic [TAG_W:0]   count;
   logic             empty;
   logic             full;

   commit_scheduler #(.AL_SIZE(AL), .REG_W(REG_W), .PS_W(PS_W)) dut (
      .clk(clk), .n_rst(n_rst),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_use_rw(dispatch_use_rw), .dispatch_rw_addr(dispatch_rw_addr),
      .dispatch_ps_write(dispatch_ps_write), .dispatch_ps_addr(dispatch_ps_addr),
      .dispatch_tag(dispatch_tag),
      .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb1_valid(wb1_valid), .wb1_tag(wb1_tag),
      .flush(flush), .flush_tag(flush_tag),
      .retire_valid(retire_valid), .reg_return(reg_return), .r_reg(r_reg),
      .ps_return(ps_return), .r_ps(r_ps),
      .count(count), .empty(empty), .full(full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Program-order model: the live instructions, oldest first.
   typedef struct {
      logic [TAG_W-1:0] tag;
      logic             use_rw;
      logic [REG_W-1:0] rw;
      logic             ps_write;
      logic [PS_W-1:0]  ps;
      bit               done;
   } ent_t;

   ent_t mq[$];
   int   m_head  = 0;
   bit   m_valid = 1'b0;

   function automatic int pos_of(input logic [TAG_W-1:0] t);
      return (int'(t) - m_head + AL) % AL;
   endfunction

   always @(negedge clk) begin : compare
      int   sz;
      int   p;
      bit   e_rdy;
      bit   e_rv;
      int   e_tag;
      ent_t e;
      sz    = mq.size();
      e_rdy = (sz < AL) && !flush;
      e_tag = (m_head + sz) % AL;
      e_rv  = (sz > 0) && mq[0].done && !(flush && int'(flush_tag) == int'(mq[0].tag));
      if (m_valid) begin
         check("count", int'(count), sz);
         check("empty", int'(empty), int'(sz == 0));
         check("full", int'(full), int'(sz == AL));
         check("dispatch_ready", int'(dispatch_ready), int'(e_rdy));
         check("dispatch_tag", int'(dispatch_tag), e_tag);
         check("retire_valid", int'(retire_valid), int'(e_rv));
         check("reg_return", int'(reg_return), int'(e_rv && mq[0].use_rw));
         check("ps_return", int'(ps_return), int'(e_rv && mq[0].ps_write));
         if (sz > 0) begin
            check("r_reg", int'(r_reg), int'(mq[0].rw));
            check("r_ps", int'(r_ps), int'(mq[0].ps));
         end
      end
      if (n_rst) begin
         mq.delete();
         m_head  = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (flush) begin
            p = pos_of(flush_tag);
            if (p < sz) begin
               while (mq.size() > p) void'(mq.pop_back());
            end
         end else begin
            p = pos_of(wb0_tag);
            if (wb0_valid && p < sz) mq[p].done = 1'b1;
            p = pos_of(wb1_tag);
            if (wb1_valid && p < sz) mq[p].done = 1'b1;
         end
         if (e_rv) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % AL;
         end
         if (dispatch_valid && e_rdy) begin
            e.tag      = TAG_W'(e_tag);
            e.use_rw   = dispatch_use_rw;
            e.rw       = dispatch_rw_addr;
            e.ps_write = dispatch_ps_write;
            e.ps       = dispatch_ps_addr;
            e.done     = 1'b0;
            mq.push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dispatch_valid    = 1'b0;
      dispatch_use_rw   = 1'b0;
      dispatch_rw_addr  = '0;
      dispatch_ps_write = 1'b0;
      dispatch_ps_addr  = '0;
      wb0_valid         = 1'b0;
      wb0_tag           = '0;
      wb1_valid         = 1'b0;
      wb1_tag           = '0;
      flush             = 1'b0;
      flush_tag         = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      n_rst = 1'b1;
      repeat (2) step();
      n_rst = 1'b0;
   endtask

   task automatic drive_dispatch(input logic u, input int rw, input logic pw, input int ps);
      dispatch_valid    = 1'b1;
      dispatch_use_rw   = u;
      dispatch_rw_addr  = REG_W'(rw);
      dispatch_ps_write = pw;
      dispatch_ps_addr  = PS_W'(ps);
   endtask

   task automatic drive_random_dispatch();
      drive_dispatch(1'($urandom), int'($urandom % 32), 1'($urandom), int'($urandom % 8));
   endtask

   function automatic logic [TAG_W-1:0] pick_tag();
      if (mq.size() > 0 && ($urandom % 4) != 0)
         return TAG_W'((m_head + int'($urandom % mq.size())) % AL);
      return TAG_W'($urandom % AL);
   endfunction

   // Complete the oldest entries until the list empties, within a bounded number of cycles.
   task automatic drain_all();
      int k;
      k = 0;
      idle_inputs();
      #1;
      while (!empty && k < 100) begin
         if (mq.size() > 0) begin wb0_valid = 1'b1; wb0_tag = mq[0].tag; end
         if (mq.size() > 1) begin wb1_valid = 1'b1; wb1_tag = mq[1].tag; end
         step();
         idle_inputs();
         #1;
         k++;
      end
      check("drain_empty", int'(empty), 1);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      n_rst = 1'b1;
      idle_inputs();

      // Reset
      do_reset();
      #1;
      check("rst_count", int'(count), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_ready", int'(dispatch_ready), 1);
      check("rst_tag", int'(dispatch_tag), 0);
      check("rst_retire", int'(retire_valid), 0);
      check("rst_reg_return", int'(reg_return), 0);
      check("rst_ps_return", int'(ps_return), 0);

      // Fill: 17 back-to-back dispatches
      for (int i = 0; i < 17; i++) begin
         drive_random_dispatch();
         #1;
         if (i < 16) check("fill_tag", int'(dispatch_tag), i);
         check("fill_ready", int'(dispatch_ready), int'(i < 16));
         step();
      end
      idle_inputs();
      #1;
      check("fill_full", int'(full), 1);
      check("fill_count", int'(count), 16);
      check("fill_ready_after", int'(dispatch_ready), 0);
      check("fill_tail", int'(dispatch_tag), 0);
      drain_all();

      // Out-of-order completion
      do_reset();
      drive_dispatch(1'b1, 3, 1'b0, 0); step();
      drive_dispatch(1'b1, 5, 1'b1, 2); step();
      drive_dispatch(1'b1, 7, 1'b0, 0); step();
      idle_inputs();
      wb0_valid = 1'b1; wb0_tag = 4'd2; #1;
      check("ooo_n_rv", int'(retire_valid), 0);
      step();
      wb0_tag = 4'd1; #1;
      check("ooo_n1_rv", int'(retire_valid), 0);
      step();
      wb0_tag = 4'd0; #1;
      check("ooo_n2_rv", int'(retire_valid), 0);
      step();
      idle_inputs(); #1;
      check("ooo_n3_rv", int'(retire_valid), 1);
      check("ooo_n3_reg", int'(r_reg), 3);
      check("ooo_n3_ps_return", int'(ps_return), 0);
      step(); #1;
      check("ooo_n4_rv", int'(retire_valid), 1);
      check("ooo_n4_reg", int'(r_reg), 5);
      check("ooo_n4_ps_return", int'(ps_return), 1);
      check("ooo_n4_ps", int'(r_ps), 2);
      step(); #1;
      check("ooo_n5_rv", int'(retire_valid), 1);
      check("ooo_n5_reg", int'(r_reg), 7);
      check("ooo_n5_ps_return", int'(ps_return), 0);
      step(); #1;
      check("ooo_empty", int'(empty), 1);

      // Wrap-around streaming
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive_random_dispatch();
         wb0_valid = (i > 0);
         wb0_tag   = TAG_W'((i + AL - 1) % AL);
         #1;
         check("wrap_tag", int'(dispatch_tag), i % AL);
         check("wrap_count_le2", int'(count <= 2), 1);
         step();
      end
      idle_inputs();
      wb0_valid = 1'b1; wb0_tag = 4'd3;
      step();
      drain_all();

      // Flush with a concurrent retire of the older head
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive_random_dispatch();
         if (i == 5) begin
            wb0_valid = 1'b1; wb0_tag = 4'd0;
            wb1_valid = 1'b1; wb1_tag = 4'd3;
         end
         step();
      end
      idle_inputs();
      flush = 1'b1; flush_tag = 4'd3; dispatch_valid = 1'b1;
      #1;
      check("flush_retire", int'(retire_valid), 1);
      check("flush_ready", int'(dispatch_ready), 0);
      step();
      idle_inputs(); #1;
      check("flush_count", int'(count), 2);
      check("flush_tail", int'(dispatch_tag), 3);
      wb0_valid = 1'b1; wb0_tag = 4'd4;
      step();
      idle_inputs();
      drive_random_dispatch(); #1;
      check("flush_new_tag", int'(dispatch_tag), 3);
      step();
      idle_inputs();
      wb0_valid = 1'b1; wb0_tag = 4'd1;
      wb1_valid = 1'b1; wb1_tag = 4'd2;
      step();
      idle_inputs();
      step();
      step(); #1;
      check("flush_new_incomplete", int'(retire_valid), 0);
      check("flush_new_count", int'(count), 1);
      drain_all();

      // Full list with retiring head, then flush on the head itself
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive_random_dispatch();
         if (i == 15) begin wb0_valid = 1'b1; wb0_tag = 4'd0; end
         step();
      end
      idle_inputs();
      drive_random_dispatch(); #1;
      check("race_full", int'(full), 1);
      check("race_retire", int'(retire_valid), 1);
      check("race_ready", int'(dispatch_ready), 0);
      step(); #1;
      check("race_count15", int'(count), 15);
      check("race_ready_next", int'(dispatch_ready), 1);
      check("race_tag_next", int'(dispatch_tag), 0);
      step();
      idle_inputs(); #1;
      check("race_count16", int'(count), 16);
      wb0_valid = 1'b1; wb0_tag = 4'd1;
      step();
      idle_inputs();
      flush = 1'b1; flush_tag = 4'd1; #1;
      check("headflush_retire", int'(retire_valid), 0);
      step();
      idle_inputs(); #1;
      check("headflush_count", int'(count), 0);
      check("headflush_empty", int'(empty), 1);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         idle_inputs();
         n_rst = (($urandom % 200) == 0);
         if (($urandom % 4) != 0) drive_random_dispatch();
         wb0_valid = 1'($urandom);
         wb0_tag   = pick_tag();
         wb1_valid = 1'($urandom);
         wb1_tag   = ($urandom % 4 == 0) ? wb0_tag : pick_tag();
         flush     = (($urandom % 25) == 0);
         flush_tag = pick_tag();
         step();
      end
      n_rst = 1'b0;
      drain_all();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
